shift_deserializer: RTL and testbench

- Serial-to-parallel receiver, the receive-side counterpart of the team's parallel-load serial shifter.
- Collects BUS_WIDTH qualified serial bits, LSB-first or MSB-first, into one parallel word.
- Presents the word on a valid/ready output register.
- Sits at the receive end of the serial link, feeding a parallel consumer such as a register file or FIFO.

---
 rtl/shift_deserializer.sv | 76 +++++++
 tb/tb_shift_deserializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles BUS_WIDTH qualified bits, LSB- or MSB-first,
// into one word presented on a valid/ready output register with overrun reporting.
module shift_deserializer #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_sht_lr,
  input  logic                 i_valid,
  input  logic                 i_shift,
  input  logic                 i_ready,
  output logic [BUS_WIDTH-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_overrun
);

  localparam int            CW   = $clog2(BUS_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(BUS_WIDTH - 1);

  logic [BUS_WIDTH-1:0] sreg;
  logic [BUS_WIDTH-1:0] sreg_next;
  logic [CW-1:0]        count;
  logic                 lsb_first_q;
  logic                 lsb_first;
  logic                 last_bit;
  logic                 can_load;

  // The first bit of a word uses the live direction input; later bits use the latched copy.
  always_comb begin
    lsb_first = (count == '0) ? i_sht_lr : lsb_first_q;
    last_bit  = (count == LAST);
    can_load  = !o_valid || i_ready;
    if (lsb_first) sreg_next = {i_shift, sreg[BUS_WIDTH-1:1]};
    else           sreg_next = {sreg[BUS_WIDTH-2:0], i_shift};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg        <= '0;
      count       <= '0;
      lsb_first_q <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;

      if (i_clear) begin
        count  <= '0;
        o_busy <= 1'b0;
      end else if (i_valid) begin
        sreg <= sreg_next;
        if (count == '0) lsb_first_q <= i_sht_lr;
        // A completion overrides the transfer clear above, keeping o_valid high with new data.
        if (last_bit) begin
          count  <= '0;
          o_busy <= 1'b0;
          if (can_load) begin
            o_data  <= sreg_next;
            o_valid <= 1'b1;
          end else begin
            o_overrun <= 1'b1;
          end
        end else begin
          count  <= count + CW'(1);
          o_busy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed scenarios plus random traffic,
// with a bit-list reference model feeding a scoreboard that a negedge monitor drains.
module tb_shift_deserializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_clear, i_sht_lr, i_valid, i_shift, i_ready;
  logic [W-1:0] o_data;
  logic         o_valid, o_busy, o_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  bit           part_bits[$];
  bit           part_lr;
  bit           m_full;
  bit           m_ov;

  bit           hold_prev;
  logic [W-1:0] data_prev;

  always #5 clk = ~clk;

  shift_deserializer #(.BUS_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_sht_lr(i_sht_lr),
    .i_valid(i_valid), .i_shift(i_shift), .i_ready(i_ready),
    .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check flags.
  task automatic applyStimulus(input logic valid, input logic sbit, input logic lr,
                               input logic clear, input logic ready);
    logic [W-1:0] w;
    bit           full_n;
    i_valid = valid; i_shift = sbit; i_sht_lr = lr; i_clear = clear; i_ready = ready;
    @(posedge clk);
    #1;
    full_n = (m_full && ready) ? 1'b0 : m_full;
    m_ov   = 1'b0;
    if (clear) begin
      part_bits.delete();
    end else if (valid) begin
      if (part_bits.size() == 0) part_lr = lr;
      part_bits.push_back(sbit);
      if (part_bits.size() == W) begin
        w = '0;
        for (int k = 0; k < W; k++) begin
          if (part_lr) w[k] = part_bits[k];
          else         w[W-1-k] = part_bits[k];
        end
        if (m_full && !ready) m_ov = 1'b1;
        else begin
          exp_q.push_back(w);
          full_n = 1'b1;
        end
        part_bits.delete();
      end
    end
    m_full = full_n;
    checkOutput("o_valid", W'(o_valid), W'(m_full));
    checkOutput("o_busy", W'(o_busy), W'(part_bits.size() != 0));
    checkOutput("o_overrun", W'(o_overrun), W'(m_ov));
  endtask

  task automatic idle(input int n, input logic ready);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'b0, ready);
  endtask

  // Bits after the first carry a random i_sht_lr to show the direction is latched.
  task automatic send_word(input logic [W-1:0] word, input logic lr, input logic ready,
                           input logic ready_last, input int max_gap);
    logic b;
    for (int k = 0; k < W; k++) begin
      b = lr ? word[k] : word[W-1-k];
      if (k > 0 && max_gap > 0) idle($urandom_range(max_gap, 1), ready);
      applyStimulus(1'b1, b, (k == 0) ? lr : 1'($urandom), 1'b0,
                    (k == W-1) ? ready_last : ready);
    end
  endtask

  // Scoreboard monitor: a word is consumed on the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && o_valid) checkOutput("o_data_hold", o_data, data_prev);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL scoreboard_empty: got %0h expected none at %0t", o_data, $time);
        end else begin
          checkOutput("o_data", o_data, exp_q.pop_front());
        end
      end
      hold_prev = o_valid && !i_ready;
      data_prev = o_data;
    end
  end

  initial begin
    rst = 1'b1;
    i_clear = 0; i_sht_lr = 0; i_valid = 0; i_shift = 0; i_ready = 0;
    m_full = 0; m_ov = 0; part_lr = 0; hold_prev = 0; data_prev = '0;
    @(posedge clk);
    #1;
    checkOutput("reset_data", o_data, '0);
    checkOutput("reset_valid", W'(o_valid), '0);
    checkOutput("reset_busy", W'(o_busy), '0);
    checkOutput("reset_overrun", W'(o_overrun), '0);
    #3 rst = 1'b0;

    $display("[TB] LSB-first word");
    send_word(8'hA5, 1'b1, 1'b1, 1'b1, 0);
    checkOutput("lsb_word", o_data, 8'hA5);
    idle(2, 1'b1);

    $display("[TB] MSB-first with gaps and direction toggles");
    send_word(8'h3C, 1'b0, 1'b1, 1'b1, 3);
    checkOutput("msb_word", o_data, 8'h3C);
    idle(2, 1'b1);

    $display("[TB] Backpressure and overrun");
    send_word(8'h11, 1'b1, 1'b0, 1'b0, 0);
    send_word(8'h22, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("overrun_held", o_data, 8'h11);
    idle(2, 1'b1);

    $display("[TB] Simultaneous accept and load");
    send_word(8'h11, 1'b1, 1'b0, 1'b0, 0);
    send_word(8'h22, 1'b0, 1'b0, 1'b1, 0);
    checkOutput("accept_load", o_data, 8'h22);
    idle(2, 1'b1);

    $display("[TB] Clear mid-word with a held word");
    send_word(8'h5A, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("clear_held", o_data, 8'h5A);
    idle(1, 1'b1);
    send_word(8'h81, 1'b1, 1'b1, 1'b1, 0);
    checkOutput("after_clear", o_data, 8'h81);
    idle(2, 1'b1);

    $display("[TB] Async reset mid-word");
    send_word(8'h77, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_data", o_data, '0);
    checkOutput("async_valid", W'(o_valid), '0);
    checkOutput("async_busy", W'(o_busy), '0);
    checkOutput("async_overrun", W'(o_overrun), '0);
    part_bits.delete();
    exp_q.delete();
    m_full = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    send_word(8'hF0, 1'b0, 1'b1, 1'b1, 0);
    checkOutput("after_reset", o_data, 8'hF0);
    idle(2, 1'b1);

    $display("[TB] Random traffic");
    for (int c = 0; c < 800; c++)
      applyStimulus(1'($urandom_range(9, 0) < 7), 1'($urandom), 1'($urandom),
                    1'($urandom_range(39, 0) == 0), 1'($urandom));
    idle(3, 1'b1);
    checkOutput("scoreboard_drained", W'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
